// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: opcode encodings, FSM states, decoded access kind, helpers.
// No logic of its own; imported by mem_stage and mem_align.
// Opcode sits in IR[WIDTH-1 -: 6].
package mem_stage_pkg;

    localparam int MEM_WIDTH = 32;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_LH = 6'h21;
    localparam logic [5:0] OP_LD = 6'h37;
    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SD = 6'h3f;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic is_mem;
        logic is_store;
        logic is_half;
        logic is_dbl;
    } mem_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Unknown opcodes decode as non-memory and simply pass through.
    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t d;
        d = '0;
        case (op)
            OP_LW: d.is_mem = 1'b1;
            OP_LH: begin d.is_mem = 1'b1; d.is_half = 1'b1; end
            OP_LD: begin d.is_mem = 1'b1; d.is_dbl = 1'b1; end
            OP_SW: begin d.is_mem = 1'b1; d.is_store = 1'b1; end
            OP_SH: begin d.is_mem = 1'b1; d.is_store = 1'b1; d.is_half = 1'b1; end
            OP_SD: begin d.is_mem = 1'b1; d.is_store = 1'b1; d.is_dbl = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    // Halfword accesses need bit 0 clear; word and doubleword need both low bits clear.
    function automatic logic misaligned(input mem_op_t d, input logic [1:0] a);
        return d.is_half ? a[0] : (|a);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables / write-data replication, LH lane select and sign-extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             req_store,
    input  logic             req_half,
    input  logic             req_h,
    input  logic [WIDTH-1:0] req_z,
    input  logic             rsp_half,
    input  logic             rsp_h,
    input  logic [WIDTH-1:0] rsp_rdata,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data
);

    always_comb begin
        be    = 4'b1111;
        wdata = req_z;
        if (req_store && req_half) begin
            be    = req_h ? 4'b1100 : 4'b0011;
            wdata = {req_z[15:0], req_z[15:0]};
        end

        load_data = rsp_rdata;
        if (rsp_half) begin
            load_data = sext16(rsp_h ? rsp_rdata[31:16] : rsp_rdata[15:0]);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: executes LW/LH/LD/SW/SH/SD on a req/ack data memory, passes other ops through.
// Latency: 1 cycle for non-memory/misaligned ops; 1 + (cycles until each beat's ack) for memory ops.
// Backpressure: IsStall holds EXE while a beat is outstanding; memory stalls us by withholding mem_ack.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] IR_in,
    input  logic [WIDTH-3:0] PC_in,
    input  logic [WIDTH-1:0] Z_in,
    input  logic [WIDTH-1:0] Z_hi_in,
    input  logic [WIDTH-1:0] Addr_in,
    output logic             IsStall,
    output logic             valid_out,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-3:0] PC_out,
    output logic [WIDTH-1:0] Z_out,
    output logic [WIDTH-1:0] LMD,
    output logic [WIDTH-1:0] LMD_hi,
    output logic             misalign,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    mem_state_t       state;
    mem_op_t          op_in;
    logic             is_store_q;
    logic             is_half_q;
    logic             is_dbl_q;
    logic             addr_h_q;
    logic [WIDTH-1:0] z_hi_q;
    logic [3:0]       be_req;
    logic [WIDTH-1:0] wdata_req;
    logic [WIDTH-1:0] load_data;
    logic             beat_done;

    assign op_in     = decode_op(IR_in[WIDTH-1 -: 6]);
    assign IsStall   = (state != ST_IDLE);
    assign beat_done = mem_req && mem_ack;

    mem_align #(.WIDTH(WIDTH)) u_align (
        .req_store (op_in.is_store),
        .req_half  (op_in.is_half),
        .req_h     (Addr_in[1]),
        .req_z     (Z_in),
        .rsp_half  (is_half_q),
        .rsp_h     (addr_h_q),
        .rsp_rdata (mem_rdata),
        .be        (be_req),
        .wdata     (wdata_req),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            valid_out  <= 1'b0;
            IR_out     <= '0;
            PC_out     <= '0;
            Z_out      <= '0;
            LMD        <= '0;
            LMD_hi     <= '0;
            misalign   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            is_store_q <= 1'b0;
            is_half_q  <= 1'b0;
            is_dbl_q   <= 1'b0;
            addr_h_q   <= 1'b0;
            z_hi_q     <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        IR_out     <= IR_in;
                        PC_out     <= PC_in;
                        Z_out      <= Z_in;
                        LMD        <= '0;
                        LMD_hi     <= '0;
                        misalign   <= 1'b0;
                        is_store_q <= op_in.is_store;
                        is_half_q  <= op_in.is_half;
                        is_dbl_q   <= op_in.is_dbl;
                        addr_h_q   <= Addr_in[1];
                        z_hi_q     <= Z_hi_in;
                        if (!op_in.is_mem) begin
                            valid_out <= 1'b1;
                        end else if (misaligned(op_in, Addr_in[1:0])) begin
                            valid_out <= 1'b1;
                            misalign  <= 1'b1;
                        end else begin
                            state     <= ST_BEAT0;
                            mem_req   <= 1'b1;
                            mem_we    <= op_in.is_store;
                            mem_addr  <= {Addr_in[WIDTH-1:2], 2'b00};
                            mem_be    <= be_req;
                            mem_wdata <= op_in.is_store ? wdata_req : '0;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (beat_done) begin
                        if (is_dbl_q) begin
                            state    <= ST_BEAT1;
                            mem_addr <= mem_addr + WIDTH'(4);
                            if (is_store_q) mem_wdata <= z_hi_q;
                            else            LMD       <= mem_rdata;
                        end else begin
                            state     <= ST_IDLE;
                            mem_req   <= 1'b0;
                            valid_out <= 1'b1;
                            if (!is_store_q) LMD <= load_data;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (beat_done) begin
                        state     <= ST_IDLE;
                        mem_req   <= 1'b0;
                        valid_out <= 1'b1;
                        if (!is_store_q) LMD_hi <= mem_rdata;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
